// File: rtl/box_overlay.sv
// box_overlay: draws a tracker bounding-box outline onto an RGB888 pixel stream, 2 clk latency.
// Define BOX_OVERLAY_CENTER_MARK_EN to also paint a 1-pixel cross through the box centre.
//
//   state | meaning
//   IDLE  | no valid box seen recently, stream passes through
//   SHOW  | last captured box valid, drawing it
//   HOLD  | tracker lost the box, keep drawing the last one for hold_cnt more frames
module box_overlay #(
   parameter int LINE_W      = 2,
   parameter int HOLD_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lcd_vs,
   input  logic        lcd_de,
   input  logic [11:0] hcount,
   input  logic [11:0] vcount,
   input  logic [23:0] pix_in,
   input  logic [11:0] hcount_l,
   input  logic [11:0] hcount_r,
   input  logic [11:0] vcount_l,
   input  logic [11:0] vcount_r,
   input  logic [23:0] box_color,
   output logic [23:0] pix_out,
   output logic        de_out,
   output logic        vs_out,
   output logic        box_valid
);

   localparam logic [11:0] LW      = 12'(LINE_W);
   localparam logic [7:0]  HOLD_LD = 8'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

   state_t      state;
   logic [7:0]  hold_cnt;
   logic [1:0]  vs_hist;
   logic        vs_rise;
   logic        capture_ok;
   logic [11:0] sh_l, sh_r, sh_vl, sh_vr;
   logic [23:0] sh_color;

   logic        in_h, in_v;
   logic        on_outline;
   logic        on_mark;
   logic        hit;

   logic        de_1, vs_1;
   logic [23:0] pix_1;

   assign vs_rise    = (vs_hist == 2'b01);
   assign capture_ok = (hcount_l < hcount_r) && (vcount_l < vcount_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_hist <= 2'b00;
      end else begin
         vs_hist <= {vs_hist[0], lcd_vs};
      end
   end

   // Frame-level decisions happen only on vs_rise so the drawn box never changes mid-frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold_cnt  <= 8'd0;
         box_valid <= 1'b0;
         sh_l      <= 12'd0;
         sh_r      <= 12'd0;
         sh_vl     <= 12'd0;
         sh_vr     <= 12'd0;
         sh_color  <= 24'd0;
      end else if (vs_rise) begin
         if (capture_ok) begin
            sh_l      <= hcount_l;
            sh_r      <= hcount_r;
            sh_vl     <= vcount_l;
            sh_vr     <= vcount_r;
            sh_color  <= box_color;
            state     <= SHOW;
            box_valid <= 1'b1;
         end else begin
            case (state)
               SHOW: begin
                  state     <= HOLD;
                  hold_cnt  <= HOLD_LD;
                  box_valid <= 1'b1;
               end
               HOLD: begin
                  if (hold_cnt == 8'd0) begin
                     state     <= IDLE;
                     box_valid <= 1'b0;
                  end else begin
                     hold_cnt  <= hold_cnt - 8'd1;
                     box_valid <= 1'b1;
                  end
               end
               default: begin
                  state     <= IDLE;
                  box_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign in_h = (hcount >= sh_l) && (hcount <= sh_r);
   assign in_v = (vcount >= sh_vl) && (vcount <= sh_vr);

   // Differences are only meaningful inside the box, where none of them can wrap.
   always_comb begin
      on_outline = 1'b0;
      if (in_h && in_v) begin
         on_outline = ((hcount - sh_l) < LW) || ((sh_r - hcount) < LW) ||
                      ((vcount - sh_vl) < LW) || ((sh_vr - vcount) < LW);
      end
   end

`ifdef BOX_OVERLAY_CENTER_MARK_EN
   logic [11:0] mid_h, mid_v;

   // (a+b)>>1 over 13 bits, folded so no sum bit is left unused.
   assign mid_h = {1'b0, sh_l[11:1]} + {1'b0, sh_r[11:1]} + {11'd0, sh_l[0] & sh_r[0]};
   assign mid_v = {1'b0, sh_vl[11:1]} + {1'b0, sh_vr[11:1]} + {11'd0, sh_vl[0] & sh_vr[0]};
   assign on_mark = in_h && in_v && ((hcount == mid_h) || (vcount == mid_v));
`else
   assign on_mark = 1'b0;
`endif

   assign hit = (on_outline || on_mark) && lcd_de && box_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_1    <= 1'b0;
         vs_1    <= 1'b0;
         pix_1   <= 24'd0;
         de_out  <= 1'b0;
         vs_out  <= 1'b0;
         pix_out <= 24'd0;
      end else begin
         de_1    <= lcd_de;
         vs_1    <= lcd_vs;
         pix_1   <= hit ? sh_color : pix_in;
         de_out  <= de_1;
         vs_out  <= vs_1;
         pix_out <= de_1 ? pix_1 : 24'd0;
      end
   end

endmodule

// File: tb/tb_box_overlay.sv
// Randomized scoreboard bench for box_overlay against a frame-level reference model.
module tb_box_overlay;

   localparam int LW = 2;
   localparam int HF = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        lcd_vs = 1'b0, lcd_de = 1'b0;
   logic [11:0] hcount = '0, vcount = '0;
   logic [23:0] pix_in = '0;
   logic [11:0] hl = '0, hr = '0, bvl = '0, bvr = '0;
   logic [23:0] box_color = '0;
   logic [23:0] pix_out;
   logic        de_out, vs_out, box_valid;

   box_overlay #(.LINE_W(LW), .HOLD_FRAMES(HF)) dut (
      .clk(clk), .rst_n(rst_n), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
      .hcount(hcount), .vcount(vcount), .pix_in(pix_in),
      .hcount_l(hl), .hcount_r(hr), .vcount_l(bvl), .vcount_r(bvr),
      .box_color(box_color), .pix_out(pix_out), .de_out(de_out),
      .vs_out(vs_out), .box_valid(box_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [23:0] pix;
      logic        de;
      logic        vs;
   } exp_t;
   exp_t q[$];

   int vectors = 0;
   int miscompares = 0;

   // Reference model: which box is drawn this frame, from frame history alone.
   bit          ever = 0, drawn = 0, pending = 0, vs_prev = 0;
   int          miss = 0;
   int          ml = 0, mr = 0, mvl = 0, mvr = 0;
   logic [23:0] mcol = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit hit(input int h, input int v);
      if (h < ml || h > mr || v < mvl || v > mvr) return 1'b0;
      if (h < ml + LW || h > mr - LW || v < mvl + LW || v > mvr - LW) return 1'b1;
`ifdef BOX_OVERLAY_CENTER_MARK_EN
      if (h == (ml + mr) / 2 || v == (mvl + mvr) / 2) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic void frame_update();
      if (hl < hr && bvl < bvr) begin
         ml = int'(hl); mr = int'(hr); mvl = int'(bvl); mvr = int'(bvr);
         mcol = box_color;
         ever = 1'b1;
         miss = 0;
      end else if (ever) begin
         miss++;
      end
      drawn = ever && (miss <= HF);
   endfunction

   function automatic void model_reset();
      ever = 0; drawn = 0; pending = 0; vs_prev = 0; miss = 0;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         check("pix_out", 32'(pix_out), 32'(e.pix));
         check("de_out", 32'(de_out), 32'(e.de));
         check("vs_out", 32'(vs_out), 32'(e.vs));
      end
   end

   task automatic drive(input bit vs, input bit de, input int h, input int v);
      exp_t        e;
      logic [23:0] px;
      @(negedge clk);
      px = 24'($urandom);
      lcd_vs = vs; lcd_de = de; hcount = 12'(h); vcount = 12'(v); pix_in = px;
      e.due = cyc + 2;
      e.de  = de;
      e.vs  = vs;
      e.pix = !de ? 24'd0 : ((drawn && hit(h, v)) ? mcol : px);
      q.push_back(e);
      // The pixel in the vs_rise cycle still sees the old box; later pixels see the new one.
      if (pending) begin
         frame_update();
         pending = 0;
      end
      if (vs && !vs_prev) pending = 1;
      vs_prev = vs;
   endtask

   function automatic int near(input int lo, input int hi);
      int x;
      case ($urandom_range(0, 4))
         0:       x = lo + int'($urandom_range(0, 3)) - 1;
         1:       x = hi - int'($urandom_range(0, 3)) + 1;
         2:       x = lo + int'($urandom_range(0, 1000)) % (hi - lo + 1);
         3:       x = (lo + hi) / 2 + int'($urandom_range(0, 2)) - 1;
         default: x = int'($urandom_range(0, 300));
      endcase
      if (x < 0) x = 0;
      if (x > 4095) x = 4095;
      return x;
   endfunction

   task automatic rpix(input bit vs);
      int rl, rr, rvl, rvr;
      if (drawn) begin
         rl = ml; rr = mr; rvl = mvl; rvr = mvr;
      end else if (hl < hr && bvl < bvr) begin
         rl = int'(hl); rr = int'(hr); rvl = int'(bvl); rvr = int'(bvr);
      end else begin
         rl = 100; rr = 200; rvl = 50; rvr = 150;
      end
      drive(vs, $urandom_range(0, 3) != 0, near(rl, rr), near(rvl, rvr));
   endtask

   task automatic frame(input int l, input int r, input int vl, input int vr,
                        input logic [23:0] col, input int npix, input bit junk);
      hl = 12'(l); hr = 12'(r); bvl = 12'(vl); bvr = 12'(vr); box_color = col;
      repeat (2) rpix(1'b0);
      repeat (3) rpix(1'b1);
      for (int i = 0; i < npix; i++) begin
         if (junk && i == npix / 2) begin
            hl = 12'($urandom); hr = 12'($urandom); bvl = 12'($urandom); bvr = 12'($urandom);
            box_color = 24'($urandom);
         end
         rpix(1'b0);
      end
      check("box_valid", 32'(box_valid), 32'(drawn));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dh[13];
      int dv[13];
      int l, r, vl, vr;
      dh = '{100, 101, 199, 200, 102, 150, 150, 150,  99, 201, 100, 150, 200};
      dv = '{ 50, 100, 150,  75,  52,  50,  51, 149,  50, 100,  49, 151, 150};

      #2 rst_n = 1'b0;
      #1;
      check("rst pix_out", 32'(pix_out), 32'd0);
      check("rst de_out", 32'(de_out), 32'd0);
      check("rst vs_out", 32'(vs_out), 32'd0);
      check("rst box_valid", 32'(box_valid), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Known box, then directed outline/interior pixels.
      frame(100, 200, 50, 150, 24'hFF0000, 20, 1'b0);
      for (int i = 0; i < 13; i++) drive(1'b0, 1'b1, dh[i], dv[i]);

      // Tracker empty encoding: hold for HF frames, then idle.
      for (int f = 0; f < HF + 1; f++) frame(12'hFFF, 12'h001, 12'hFFF, 12'h001, 24'h00FF00, 30, f[0]);
      frame(12'hFFF, 12'h001, 12'hFFF, 12'h001, 24'h00FF00, 40, 1'b0);

      frame(20, 60, 10, 30, 24'h0000FF, 40, 1'b0);
      frame(30, 90, 5, 70, 24'h123456, 40, 1'b1);
      frame(5, 5, 3, 90, 24'hABCDEF, 30, 1'b0);
      frame(0, 3, 0, 1, 24'h777777, 30, 1'b0);
      frame(4000, 4095, 4000, 4095, 24'h0F0F0F, 30, 1'b0);

      // Reset while outline pixels are in flight.
      frame(100, 200, 50, 150, 24'hFF0000, 10, 1'b0);
      drive(1'b0, 1'b1, 100, 60);
      drive(1'b0, 1'b1, 150, 50);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst pix_out", 32'(pix_out), 32'd0);
      check("midrst de_out", 32'(de_out), 32'd0);
      check("midrst vs_out", 32'(vs_out), 32'd0);
      check("midrst box_valid", 32'(box_valid), 32'd0);
      q.delete();
      model_reset();
      lcd_de = 1'b0; lcd_vs = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      frame(12'hFFF, 12'h001, 12'hFFF, 12'h001, 24'h00FF00, 30, 1'b0);
      frame(100, 200, 50, 150, 24'h00FFFF, 30, 1'b0);

      for (int f = 0; f < 12; f++) begin
         l  = int'($urandom_range(0, 300));
         r  = l + int'($urandom_range(1, 100));
         vl = int'($urandom_range(0, 200));
         vr = vl + int'($urandom_range(1, 80));
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 0) r = l;
            else begin l = 12'hFFF; r = 12'h001; end
         end
         frame(l, r, vl, vr, 24'($urandom), 40, (f % 3) == 0);
      end

      repeat (3) drive(1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      check("drain", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
